// File: rtl/sar_datapath.sv
// rtl/sar_datapath.sv - successive-approximation datapath for the SAR ADC
//
// Purpose: holds the accepted-bit register and the one-hot trial mask for a
// SAR conversion. It advances one bit trial per enabled step, drives the DAC
// trial code, flags the FSM when all N bits are decided, and latches the
// final code with a one-cycle valid pulse.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset, dominates every other input
//   clc       arm: restart conversion from the MSB
//   hs, hp    shift / present enables from the SAR FSM
//   hf        finish: latch result
//   cmp       comparator, 1 = Vin >= Vdac
//   zi        all N bits decided (to FSM)
//   dac_code  code applied to the DAC
//   result    last completed (or finished-early) conversion
//   valid     one-cycle pulse when result updates
//
// Configuration: define SAR_CMP_SYNC_EN to pass cmp through a 2-flop
// synchronizer and spend 3 cycles per bit trial.

module sar_datapath #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clc,
   input  logic         hs,
   input  logic         hp,
   input  logic         hf,
   input  logic         cmp,
   output logic         zi,
   output logic [N-1:0] dac_code,
   output logic [N-1:0] result,
   output logic         valid
);

   localparam logic [N-1:0] MSB = {1'b1, {(N-1){1'b0}}};

   logic [N-1:0] code;
   logic [N-1:0] mask;
   logic [N-1:0] code_n;
   logic [N-1:0] mask_n;
   logic         done;
   logic         done_n;
   // High when the registered dac_code currently carries the trial bit, so
   // the comparator is looking at code|mask. A trial may only be decided
   // while this holds; after hp drops the first re-enabled cycle re-presents.
   logic         shown;
   logic         active;
   logic         dec;

`ifdef SAR_CMP_SYNC_EN
   logic         cmp_s1;
   logic         cmp_s2;
   logic [1:0]   phase;
   logic [1:0]   phase_n;

   assign dec = cmp_s2;
`else
   assign dec = cmp;
`endif

   assign zi = done;

   always_comb begin
      code_n = code;
      mask_n = mask;
      done_n = done;
      active = hs & hp & ~done;
`ifdef SAR_CMP_SYNC_EN
      phase_n = phase;
`endif
      if (clc) begin
         code_n = '0;
         mask_n = MSB;
         done_n = 1'b0;
`ifdef SAR_CMP_SYNC_EN
         phase_n = 2'd0;
`endif
      end else if (hf) begin
         // Finish takes priority over a step; trial state is held.
         code_n = code;
      end else if (active) begin
`ifdef SAR_CMP_SYNC_EN
         if (!shown) begin
            // DAC did not show the trial; restart the synchronizer fill.
            phase_n = 2'd0;
         end else if (phase != 2'd2) begin
            phase_n = phase + 2'd1;
         end else begin
            phase_n = 2'd0;
            if (dec) code_n = code | mask;
            mask_n = mask >> 1;
            if (mask[0]) done_n = 1'b1;
         end
`else
         if (shown) begin
            if (dec) code_n = code | mask;
            mask_n = mask >> 1;
            if (mask[0]) done_n = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         code     <= '0;
         mask     <= '0;
         done     <= 1'b0;
         shown    <= 1'b0;
         dac_code <= '0;
         result   <= '0;
         valid    <= 1'b0;
`ifdef SAR_CMP_SYNC_EN
         phase    <= 2'd0;
         cmp_s1   <= 1'b0;
         cmp_s2   <= 1'b0;
`endif
      end else begin
         code  <= code_n;
         mask  <= mask_n;
         done  <= done_n;
         shown <= hp;
         // Registered from the next-state values so the DAC shows the new
         // trial in the same cycle the comparator must settle against it.
         dac_code <= hp ? (code_n | mask_n) : code_n;
         valid    <= hf & ~clc;
         if (hf && !clc) result <= code;
`ifdef SAR_CMP_SYNC_EN
         phase  <= phase_n;
         cmp_s1 <= cmp;
         cmp_s2 <= cmp_s1;
`endif
      end
   end

endmodule

// File: tb/tb_sar_datapath.sv
// tb/tb_sar_datapath.sv - scoreboard bench for sar_datapath

module tb_sar_datapath;

   localparam int N = 8;
`ifdef SAR_CMP_SYNC_EN
   localparam int TPB = 3;
`else
   localparam int TPB = 1;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         clc;
   logic         hs;
   logic         hp;
   logic         hf;
   logic         cmp;
   logic         zi;
   logic [N-1:0] dac_code;
   logic [N-1:0] result;
   logic         valid;
   logic [N-1:0] vin;

   int tests = 0;
   int fails = 0;
   logic [N-1:0] exp_q[$];
   logic         prev_valid = 1'b0;

   sar_datapath #(.N(N)) dut (
      .clk(clk), .rst(rst), .clc(clc), .hs(hs), .hp(hp), .hf(hf),
      .cmp(cmp), .zi(zi), .dac_code(dac_code), .result(result), .valid(valid)
   );

   always #5 clk = ~clk;

   // Bench comparator: analog input vs the DAC output.
   assign cmp = (vin >= dac_code);

   // Bits of v above trial position k, i.e. what a correct SAR has accepted.
   function automatic logic [7:0] prefix(input logic [7:0] v, input int k);
      logic [7:0] keep;
      keep = ~(8'hFF >> k);
      return v & keep;
   endfunction

   function automatic logic [7:0] trial(input logic [7:0] v, input int k);
      logic [7:0] bitk;
      bitk = 8'h80 >> k;
      return prefix(v, k) | bitk;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic arm(input logic [7:0] v);
      vin = v;
      clc = 1'b1; hs = 1'b1; hp = 1'b1; hf = 1'b0;
      cyc();
      clc = 1'b0;
      chk("arm_dac", dac_code, 8'h80);
      chk("arm_zi", zi, 0);
   endtask

   task automatic steps(input logic [7:0] v, input int k0, input int k1);
      hs = 1'b1; hp = 1'b1;
      for (int k = k0; k < k1; k++) begin
         chk("dac_trial", dac_code, trial(v, k));
         chk("zi_busy", zi, 0);
         repeat (TPB) cyc();
      end
   endtask

   task automatic finish(input logic [7:0] v);
      chk("zi_done", zi, 1);
      cyc();  // FSM's extra shift cycle after zi
      chk("dac_after_done", dac_code, v);
      chk("zi_hold", zi, 1);
      hs = 1'b0; hp = 1'b0; hf = 1'b1;
      exp_q.push_back(v);
      cyc();
      hf = 1'b0;
      cyc();
      chk("valid_low", valid, 0);
   endtask

   task automatic full(input logic [7:0] v);
      arm(v);
      steps(v, 0, N);
      finish(v);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a result.
   initial begin
      logic [N-1:0] e;
      forever begin
         @(negedge clk);
         if (valid) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_valid result=%h", result);
            end else begin
               e = exp_q.pop_front();
               if (result !== e) begin
                  fails++;
                  $display("FAIL result actual=%h expected=%h", result, e);
               end
            end
            tests++;
            if (prev_valid) begin
               fails++;
               $display("FAIL valid_width valid high two cycles actual=1 expected=0");
            end
         end
         prev_valid = valid;
      end
   end

   initial begin
      logic [7:0] v;
      rst = 1'b1; clc = 1'b0; hs = 1'b0; hp = 1'b0; hf = 1'b0; vin = '0;
      cyc();
      cyc();
      chk("rst_dac", dac_code, 0);
      chk("rst_result", result, 0);
      chk("rst_zi", zi, 0);
      chk("rst_valid", valid, 0);
      rst = 1'b0;

      full(8'hA5);
      full(8'hFF);
      full(8'h00);
      repeat (6) full(8'($urandom_range(0, 255)));

      // hs without hp freezes the conversion mid-way
      v = 8'($urandom_range(0, 255));
      arm(v);
      steps(v, 0, 3);
      hp = 1'b0;
      repeat (5) begin
         cyc();
         chk("hold_dac", dac_code, prefix(v, 3));
         chk("hold_zi", zi, 0);
      end
      hp = 1'b1;
      cyc();
      steps(v, 3, N);
      finish(v);

      // early finish latches partial code, then clc restarts
      arm(8'h3C);
      steps(8'h3C, 0, 4);
      hf = 1'b1;
      exp_q.push_back(prefix(8'h3C, 4));
      cyc();
      hf = 1'b0;
      arm(8'h81);
      chk("result_held_arm", result, 8'h30);
      steps(8'h81, 0, N);
      chk("result_held", result, 8'h30);
      finish(8'h81);

      // reset mid-conversion clears every output
      v = 8'($urandom_range(1, 255));
      arm(v);
      steps(v, 0, 3);
      rst = 1'b1;
      cyc();
      rst = 1'b0; hs = 1'b0; hp = 1'b0;
      chk("midrst_dac", dac_code, 0);
      chk("midrst_result", result, 0);
      chk("midrst_zi", zi, 0);
      chk("midrst_valid", valid, 0);

      full(8'($urandom_range(0, 255)));

      cyc();
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
